// File: rtl/clock_divider_ctrl.sv
// Toggle clock divider run controller: start/stop sequencing, boundary-only reload, tick per toggle.
// All outputs registered (1 cin edge); div_load is not back-pressured, a second load while one is pending is dropped.
module clock_divider_ctrl #(
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_MAX = 1
) (
  input  logic             cin,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_max,
  input  logic             div_load,
  output logic             div_ack,
  output logic             cout,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] active_max
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] counter, counter_nxt;
  logic [WIDTH-1:0] pend_val, pend_val_nxt;
  logic [WIDTH-1:0] max_nxt;
  logic             pending, pending_nxt;
  logic             cout_nxt, tick_nxt, ack_nxt, busy_nxt;
  logic             terminal, apply;

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      cout       <= 1'b0;
      tick       <= 1'b0;
      div_ack    <= 1'b0;
      busy       <= 1'b0;
      active_max <= WIDTH'(DEFAULT_MAX);
      pending    <= 1'b0;
      pend_val   <= '0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      cout       <= cout_nxt;
      tick       <= tick_nxt;
      div_ack    <= ack_nxt;
      busy       <= busy_nxt;
      active_max <= max_nxt;
      pending    <= pending_nxt;
      pend_val   <= pend_val_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter;
    cout_nxt     = cout;
    tick_nxt     = 1'b0;
    ack_nxt      = 1'b0;
    max_nxt      = active_max;
    pending_nxt  = pending;
    pend_val_nxt = pend_val;
    apply        = 1'b0;
    terminal     = (counter == active_max);

    case (state)
      IDLE: begin
        counter_nxt = '0;
        cout_nxt    = 1'b0;
        apply       = pending;
        if (en) state_nxt = RUN;
      end
      RUN, STOP: begin
        if (!en && !cout) begin
          // Low phase may be cut short: output already low, so no runt.
          state_nxt   = IDLE;
          counter_nxt = '0;
        end else begin
          if (terminal) begin
            counter_nxt = '0;
            cout_nxt    = ~cout;
            tick_nxt    = 1'b1;
            apply       = pending;
          end else begin
            counter_nxt = counter + WIDTH'(1);
          end
          // A stop request during the high phase finishes that phase first.
          if (en)            state_nxt = RUN;
          else if (terminal) state_nxt = IDLE;
          else               state_nxt = STOP;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
        cout_nxt    = 1'b0;
      end
    endcase

    // Capture needs pending clear and apply needs it set, so they never share an edge.
    if (apply) begin
      max_nxt     = pend_val;
      ack_nxt     = 1'b1;
      pending_nxt = 1'b0;
    end else if (div_load && !pending) begin
      pending_nxt  = 1'b1;
      pend_val_nxt = div_max;
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl: start/stop, reload, seamless restart, reset.
module tb_clock_divider_ctrl;

  logic        cin = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] div_max;
  logic        div_load;
  logic        div_ack;
  logic        cout;
  logic        tick;
  logic        busy;
  logic [31:0] active_max;

  int checks = 0;
  int errors = 0;

  clock_divider_ctrl #(.WIDTH(32), .DEFAULT_MAX(1)) dut (
    .cin        (cin),
    .rst        (rst),
    .en         (en),
    .div_max    (div_max),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .cout       (cout),
    .tick       (tick),
    .busy       (busy),
    .active_max (active_max)
  );

  always #5 cin = ~cin;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge cin);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic c, input logic t, input logic b);
    chk({tag, ".cout"}, 32'(cout), 32'(c));
    chk({tag, ".tick"}, 32'(tick), 32'(t));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_max = '0; div_load = 1'b0;
    step(2);
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.ack", 32'(div_ack), 32'd0);
    chk("reset.max", active_max, 32'd1);

    // 1: default ratio, rise 2 edges after RUN entry, period 4
    rst = 1'b0;
    step();
    chk_out("idle", 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    step(); chk_out("t1.e1", 1'b0, 1'b0, 1'b1);
    step(); chk_out("t1.e2", 1'b0, 1'b0, 1'b1);
    step(); chk_out("t1.e3", 1'b1, 1'b1, 1'b1);
    step(); chk_out("t1.e4", 1'b1, 1'b0, 1'b1);
    step(); chk_out("t1.e5", 1'b0, 1'b1, 1'b1);
    step(); chk_out("t1.e6", 1'b0, 1'b0, 1'b1);
    step(); chk_out("t1.e7", 1'b1, 1'b1, 1'b1);

    // 2: load max=3 in IDLE, run, reload max=0 mid high phase
    rst = 1'b1; #1; rst = 1'b0; en = 1'b0;
    step();
    div_max = 32'd3; div_load = 1'b1;
    step(); div_load = 1'b0;
    chk("t2.cap_ack", 32'(div_ack), 32'd0);
    step();
    chk("t2.idle_ack", 32'(div_ack), 32'd1);
    chk("t2.idle_max", active_max, 32'd3);
    en = 1'b1;
    step(); chk("t2.ack_clr", 32'(div_ack), 32'd0);
    step(3); chk_out("t2.r4", 1'b0, 1'b0, 1'b1);
    step(); chk_out("t2.r5", 1'b1, 1'b1, 1'b1);
    div_max = 32'd0; div_load = 1'b1;
    step(); div_load = 1'b0;
    step(2);
    chk("t2.r8.ack", 32'(div_ack), 32'd0);
    chk("t2.r8.max", active_max, 32'd3);
    chk_out("t2.r8", 1'b1, 1'b0, 1'b1);
    step();
    chk("t2.r9.ack", 32'(div_ack), 32'd1);
    chk("t2.r9.max", active_max, 32'd0);
    chk_out("t2.r9", 1'b0, 1'b1, 1'b1);
    step();
    chk("t2.r10.ack", 32'(div_ack), 32'd0);
    chk_out("t2.r10", 1'b1, 1'b1, 1'b1);
    step(); chk_out("t2.r11", 1'b0, 1'b1, 1'b1);

    // back to max=3 at a terminal edge
    div_max = 32'd3; div_load = 1'b1;
    step(); div_load = 1'b0;
    chk_out("t3.r12", 1'b1, 1'b1, 1'b1);
    step();
    chk("t3.r13.ack", 32'(div_ack), 32'd1);
    chk("t3.r13.max", active_max, 32'd3);
    chk_out("t3.r13", 1'b0, 1'b1, 1'b1);
    step(3); chk_out("t3.r16", 1'b0, 1'b0, 1'b1);
    step(); chk_out("t3.r17", 1'b1, 1'b1, 1'b1);

    // 3: en=0 with cout=1 at counter=1
    step(); en = 1'b0;
    step(); chk_out("t3.stop1", 1'b1, 1'b0, 1'b1);
    step(); chk_out("t3.stop2", 1'b1, 1'b0, 1'b1);
    step(); chk_out("t3.fall", 1'b0, 1'b1, 1'b0);
    step(); chk_out("t3.idle", 1'b0, 1'b0, 1'b0);

    // 4: en 1->0->1 inside STOP is seamless
    en = 1'b1;
    step(4); chk_out("t4.s4", 1'b0, 1'b0, 1'b1);
    step(); chk_out("t4.s5", 1'b1, 1'b1, 1'b1);
    step(); en = 1'b0;
    step(); chk_out("t4.s7", 1'b1, 1'b0, 1'b1);
    en = 1'b1;
    step(); chk_out("t4.s8", 1'b1, 1'b0, 1'b1);
    step(); chk_out("t4.s9", 1'b0, 1'b1, 1'b1);
    step(3); chk_out("t4.s12", 1'b0, 1'b0, 1'b1);
    step(); chk_out("t4.s13", 1'b1, 1'b1, 1'b1);

    // 5: loads of 5 then 9 before terminal, first wins
    div_max = 32'd5; div_load = 1'b1;
    step();
    div_max = 32'd9;
    step(); div_load = 1'b0;
    chk("t5.s15.ack", 32'(div_ack), 32'd0);
    chk("t5.s15.max", active_max, 32'd3);
    step(2);
    chk("t5.s17.ack", 32'(div_ack), 32'd1);
    chk("t5.s17.max", active_max, 32'd5);
    chk_out("t5.s17", 1'b0, 1'b1, 1'b1);
    step();
    chk("t5.s18.ack", 32'(div_ack), 32'd0);
    step(4); chk_out("t5.s22", 1'b0, 1'b0, 1'b1);
    step(); chk_out("t5.s23", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5.no_second_ack", 32'(div_ack), 32'd0);
    end
    chk("t5.s29.max", active_max, 32'd5);
    chk_out("t5.s29", 1'b0, 1'b1, 1'b1);

    // 6: reset mid high phase with a load pending
    step(6); chk_out("t6.s35", 1'b1, 1'b1, 1'b1);
    div_max = 32'd7; div_load = 1'b1;
    step(); div_load = 1'b0; en = 1'b0;
    chk_out("t6.s36", 1'b1, 1'b0, 1'b0 | busy);
    #2 rst = 1'b1;
    #1;
    chk_out("t6.async", 1'b0, 1'b0, 1'b0);
    chk("t6.async.max", active_max, 32'd1);
    chk("t6.async.ack", 32'(div_ack), 32'd0);
    step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6.no_ack", 32'(div_ack), 32'd0);
      chk("t6.max_kept", active_max, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
